// File: rtl/fft_frame_scheduler.sv
// Frame sequencer in front of the pipelined radix-2 FFT: turns a valid/ready sample
// stream into contiguous, gap-separated frames and tracks frames in flight.
module fft_frame_scheduler #(
    parameter int LOG2N        = 6,
    parameter int DW           = 32,
    parameter int GAP          = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_real,
    input  logic [DW-1:0] s_img,
    input  logic          s_last,
    output logic          fft_start,
    output logic          fft_over,
    output logic [DW-1:0] fft_real,
    output logic [DW-1:0] fft_img,
    input  logic          done_start,
    input  logic          done_end,
    output logic          m_sof,
    output logic          m_eof,
    output logic [3:0]    inflight,
    output logic [15:0]   frames_done,
    output logic          busy,
    input  logic          clr_err,
    output logic          err_len,
    output logic          err_underrun,
    output logic          err_spurious
);

    localparam int IW = (LOG2N > 0) ? LOG2N : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'((1 << LOG2N) - 1);
    localparam logic [7:0]    GAP_LAST = 8'(GAP - 1);
    localparam logic [3:0]    MAX_IF   = 4'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_GAP} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    gap_cnt;
    logic          armed;

    logic accept;
    logic slot_in;
    logic at_end;
    logic over_evt;
    logic len_evt;
    logic und_evt;
    logic eof_ok;
    logic spur_evt;

    // armed keeps s_ready low until the first clock after reset release
    assign s_ready = armed && ((state == S_LOAD) ||
                               ((state == S_IDLE) && (inflight < MAX_IF)));
    assign accept  = s_valid && s_ready;
    assign busy    = (state != S_IDLE) || (inflight != 4'd0);

    always_comb begin
        slot_in  = (state == S_LOAD) || ((state == S_IDLE) && accept);
        at_end   = 1'b0;
        if (state == S_IDLE) begin
            at_end = (LOG2N == 0);
        end else if ((state == S_LOAD) || (state == S_PAD)) begin
            at_end = (idx == LAST_IDX);
        end
        over_evt = (slot_in || (state == S_PAD)) && at_end;
        // s_last only counts on an accepted sample; missing or early both flag a length error
        len_evt  = slot_in && ((accept && s_last && !at_end) ||
                               (at_end && !(accept && s_last)));
        und_evt  = (state == S_LOAD) && !s_valid;
        eof_ok   = done_end && (inflight != 4'd0);
        spur_evt = done_end && (inflight == 4'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            idx          <= '0;
            gap_cnt      <= '0;
            armed        <= 1'b0;
            fft_start    <= 1'b0;
            fft_over     <= 1'b0;
            fft_real     <= '0;
            fft_img      <= '0;
            m_sof        <= 1'b0;
            m_eof        <= 1'b0;
            inflight     <= '0;
            frames_done  <= '0;
            err_len      <= 1'b0;
            err_underrun <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            armed     <= 1'b1;
            fft_start <= 1'b0;
            fft_over  <= over_evt;
            fft_real  <= accept ? s_real : '0;
            fft_img   <= accept ? s_img  : '0;
            m_sof     <= done_start;
            m_eof     <= done_end;
            inflight  <= inflight + {3'b000, over_evt} - {3'b000, eof_ok};
            if (eof_ok) begin
                frames_done <= frames_done + 16'd1;
            end
            err_len      <= (err_len      && !clr_err) || len_evt;
            err_underrun <= (err_underrun && !clr_err) || und_evt;
            err_spurious <= (err_spurious && !clr_err) || spur_evt;

            case (state)
                S_IDLE: begin
                    gap_cnt <= '0;
                    if (accept) begin
                        fft_start <= 1'b1;
                        idx       <= IW'(1);
                        if (over_evt) begin
                            state <= S_GAP;
                        end else if (s_last) begin
                            state <= S_PAD;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    gap_cnt <= '0;
                    idx     <= idx + IW'(1);
                    if (over_evt) begin
                        state <= S_GAP;
                    end else if (accept && s_last) begin
                        state <= S_PAD;
                    end
                end
                S_PAD: begin
                    gap_cnt <= '0;
                    idx     <= idx + IW'(1);
                    if (over_evt) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    idx <= '0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler: the driver queues expected frame samples,
// a negedge monitor pops and compares them as frames appear on the FFT side.
module tb_fft_frame_scheduler;
    localparam int LOG2N = 6;
    localparam int N     = 64;
    localparam int DW    = 32;
    localparam int GAP   = 4;
    localparam int MAXF  = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_real = '0;
    logic [DW-1:0] s_img = '0;
    logic          s_last = 1'b0;
    logic          fft_start, fft_over;
    logic [DW-1:0] fft_real, fft_img;
    logic          done_start = 1'b0;
    logic          done_end = 1'b0;
    logic          m_sof, m_eof;
    logic [3:0]    inflight;
    logic [15:0]   frames_done;
    logic          busy;
    logic          clr_err = 1'b0;
    logic          err_len, err_underrun, err_spurious;

    fft_frame_scheduler #(.LOG2N(LOG2N), .DW(DW), .GAP(GAP), .MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_img(s_img), .s_last(s_last),
        .fft_start(fft_start), .fft_over(fft_over), .fft_real(fft_real), .fft_img(fft_img),
        .done_start(done_start), .done_end(done_end), .m_sof(m_sof), .m_eof(m_eof),
        .inflight(inflight), .frames_done(frames_done), .busy(busy), .clr_err(clr_err),
        .err_len(err_len), .err_underrun(err_underrun), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s;
        logic          o;
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        int            pos;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   in_frame = 0;
    int   fd_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame: sample p carries upstream value v (img = v+256) or zero when padded/dropped
    function automatic void push_frame(input int last_j, input int drop_j, input int drop_len);
        exp_t e;
        for (int p = 0; p < N; p++) begin
            int  v;
            bit  zero;
            zero = 1'b0;
            if (p < drop_j) v = p;
            else if (p < drop_j + drop_len) begin v = 0; zero = 1'b1; end
            else v = p - drop_len;
            if (v > last_j) zero = 1'b1;
            e.s   = (p == 0);
            e.o   = (p == N - 1);
            e.r   = zero ? '0 : DW'(v);
            e.i   = zero ? '0 : DW'(v + 256);
            e.pos = p;
            exp_q.push_back(e);
        end
    endfunction

    task automatic stream(input int n, input int last_j, input int drop_j, input int drop_len,
                          input int stop_j, input bit done_last);
        int j = 0;
        int dropped = 0;
        int waits = 0;
        bit acc;
        while (j < n && j != stop_j) begin
            if (j == drop_j && dropped < drop_len) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                step();
                dropped++;
            end else begin
                s_valid  = 1'b1;
                s_real   = DW'(j);
                s_img    = DW'(j + 256);
                s_last   = (j == last_j);
                done_end = done_last && (j == n - 1);
                acc      = s_ready;
                step();
                done_end = 1'b0;
                if (acc) begin
                    j++;
                    waits = 0;
                end else begin
                    waits++;
                    if (waits > 500) begin
                        check("ready_timeout", 32'(j), 32'(n));
                        break;
                    end
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_real  = '0;
        s_img   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_start_over"}, {30'd0, fft_start, fft_over}, 0);
        check({tag, "_fft_real"}, fft_real, 0);
        check({tag, "_fft_img"}, fft_img, 0);
        check({tag, "_sof_eof"}, {30'd0, m_sof, m_eof}, 0);
        check({tag, "_inflight"}, 32'(inflight), 0);
        check({tag, "_frames_done"}, 32'(frames_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_errs"}, {29'd0, err_len, err_underrun, err_spurious}, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_all_zero("reset");
        exp_q.delete();
        in_frame = 1'b0;
        fd_exp = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
    endtask

    // Called in the fft_over cycle: s_ready must stay low for exactly GAP cycles
    task automatic check_gap();
        check("over_pulse", 32'(fft_over), 1);
        for (int k = 0; k < GAP; k++) begin
            check("gap_ready_low", 32'(s_ready), 0);
            step();
        end
        check("gap_ready_high", 32'(s_ready), 1);
    endtask

    task automatic drain(input int inflight_after);
        done_end = 1'b1;
        step();
        done_end = 1'b0;
        fd_exp++;
        check("drain_m_eof", 32'(m_eof), 1);
        check("drain_inflight", 32'(inflight), 32'(inflight_after));
        check("drain_frames_done", 32'(frames_done), 32'(fd_exp));
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (!in_frame && fft_start) in_frame = 1'b1;
                if (in_frame) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        in_frame = 1'b0;
                        $display("FAIL sb_empty actual start=%0b over=%0b real=%0h required=no output",
                                 fft_start, fft_over, fft_real);
                    end else begin
                        e = exp_q.pop_front();
                        if ({fft_start, fft_over, fft_real, fft_img} !== {e.s, e.o, e.r, e.i}) begin
                            bad++;
                            $display("FAIL sb_sample pos=%0d actual s=%0b o=%0b r=%0h i=%0h required s=%0b o=%0b r=%0h i=%0h",
                                     e.pos, fft_start, fft_over, fft_real, fft_img, e.s, e.o, e.r, e.i);
                        end
                        if (e.o) in_frame = 1'b0;
                    end
                end else begin
                    total++;
                    if (fft_over || fft_real != '0 || fft_img != '0) begin
                        bad++;
                        $display("FAIL idle_out actual over=%0b real=%0h img=%0h required all 0",
                                 fft_over, fft_real, fft_img);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        rstn = 1'b1;
        step();

        // single contiguous frame
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 1000, 1'b0);
        check("s1_inflight", 32'(inflight), 1);
        check_gap();
        check("s1_busy", 32'(busy), 1);
        drain(0);
        check("s1_busy_after", 32'(busy), 0);

        // back-to-back frames until the in-flight limit throttles input
        do_reset();
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 1000, 1'b0);
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 1000, 1'b0);
        check("s2_inflight_full", 32'(inflight), 2);
        repeat (GAP) step();
        for (int k = 0; k < 20; k++) begin
            check("s2_ready_throttled", 32'(s_ready), 0);
            step();
        end
        drain(1);
        check("s2_ready_reopen", 32'(s_ready), 1);
        drain(0);

        // early s_last on the 40th sample
        push_frame(39, 1000, 0);
        stream(40, 39, 1000, 0, 1000, 1'b0);
        repeat (30) step();
        check("s3_err_len", 32'(err_len), 1);
        check("s3_err_underrun", 32'(err_underrun), 0);
        pulse_clr();
        check("s3_err_len_clr", 32'(err_len), 0);
        drain(0);

        // s_valid dropped for 3 cycles at idx 10
        push_frame(60, 10, 3);
        stream(61, 60, 10, 3, 1000, 1'b0);
        check("s4_over_at_63", 32'(fft_over), 1);
        repeat (10) step();
        check("s4_err_underrun", 32'(err_underrun), 1);
        check("s4_err_len", 32'(err_len), 0);
        pulse_clr();
        check("s4_err_underrun_clr", 32'(err_underrun), 0);
        drain(0);

        // spurious done_end, clear-vs-set priority, coincident over and eof
        done_end = 1'b1;
        step();
        done_end = 1'b0;
        check("s5_err_spurious", 32'(err_spurious), 1);
        check("s5_inflight", 32'(inflight), 0);
        check("s5_frames_done", 32'(frames_done), 32'(fd_exp));
        check("s5_m_eof_copy", 32'(m_eof), 1);
        done_end = 1'b1;
        clr_err  = 1'b1;
        step();
        done_end = 1'b0;
        clr_err  = 1'b0;
        check("s5_set_beats_clr", 32'(err_spurious), 1);
        pulse_clr();
        check("s5_spurious_clr", 32'(err_spurious), 0);
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 1000, 1'b0);
        repeat (10) step();
        check("s5_inflight_one", 32'(inflight), 1);
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 1000, 1'b1);
        fd_exp++;
        check("s5_coincident_eof", 32'(m_eof), 1);
        check("s5_coincident_inflight", 32'(inflight), 1);
        step();
        check("s5_inflight_hold", 32'(inflight), 1);
        check("s5_frames_done_inc", 32'(frames_done), 32'(fd_exp));
        check("s5_no_spurious", 32'(err_spurious), 0);
        repeat (10) step();
        drain(0);

        // reset mid-frame at idx 30, then a clean frame
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 30, 1'b0);
        do_reset();
        repeat (80) step();
        check("s6_inflight_after_reset", 32'(inflight), 0);
        push_frame(63, 1000, 0);
        stream(64, 63, 1000, 0, 1000, 1'b0);
        check("s6_inflight", 32'(inflight), 1);
        check_gap();

        repeat (5) step();
        check("sb_leftover", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
